sem_monitor_bridge: RTL and testbench
=====================================

// Module: sem_monitor_bridge
// PURPOSE
//  Parametrised successor to the SEM wrapper's UART monitor path. Sits between the SEM controller's
//  monitor/status ports and an on-chip host: buffers monitor bytes in TX/RX FIFOs instead of a UART,
//  tracks the SEM phase with an FSM, counts correction and uncorrectable events, and runs a heartbeat watchdog.
// PARAMETERS
//  FIFO_DEPTH   16    entries per FIFO; power of two, >=2
//  CNT_WIDTH    16    width of the event counters
//  HB_TIMEOUT   1024  clk_icap cycles without a heartbeat (in OBSERVE) before hb_timeout asserts
// PORTS
//  clk_icap            in   1          single clock, all logic rising-edge
//  reset               in   1          synchronous, active-high
//  status_heartbeat    in   1          SEM heartbeat pulse
//  status_initialization in 1          SEM init phase
//  status_observation  in   1          SEM observation phase
//  status_correction   in   1          SEM correction phase
//  status_uncorrectable in  1          SEM uncorrectable error
//  monitor_txdata      in   8          byte from SEM
//  monitor_txwrite     in   1          SEM writes monitor_txdata this cycle
//  monitor_txfull      out  1          TX FIFO full
//  monitor_rxdata      out  8          head of RX FIFO (first-word fall-through)
//  monitor_rxread      in   1          SEM pops RX FIFO
//  monitor_rxempty     out  1          RX FIFO empty
//  host_rd_data        out  8          head of TX FIFO (first-word fall-through)
//  host_rd_valid       out  1          TX FIFO not empty
//  host_rd_ready       in   1          host pops TX FIFO when valid&ready
//  host_wr_data        in   8          command byte to SEM
//  host_wr_valid       in   1          host push, accepted when valid&ready
//  host_wr_ready       out  1          RX FIFO not full
//  count_clear         in   1          clears counters and sticky flags
//  corr_count          out  CNT_WIDTH  correction events, saturating
//  uncorr_count        out  CNT_WIDTH  uncorrectable events, saturating
//  hb_timeout          out  1          sticky heartbeat-timeout flag
//  tx_overflow         out  1          sticky flag: write to full TX FIFO
//  sem_state           out  2          0 INIT, 1 OBSERVE, 2 CORRECT, 3 FAULT
// BEHAVIOUR
//  - Reset, synchronous: both FIFOs empty, pointers 0.
//    Output values after reset: monitor_txfull=0, monitor_rxempty=1, host_rd_valid=0, host_wr_ready=1,
//    counters=0, hb_timeout=0, tx_overflow=0, sem_state=INIT.
//  - Reset mid-transfer discards all FIFO contents.
//  - FIFOs: occupancy counter is $clog2(FIFO_DEPTH)+1 bits wide. Pointers wrap modulo FIFO_DEPTH.
//    A push/pop is visible at the outputs on the next edge. Zero bubble: one push and one pop per cycle.
//  - Simultaneous push and pop on a non-empty FIFO: occupancy is unchanged.
//  - Simultaneous push and pop on an empty FIFO: only the push happens, because valid was low.
//  - monitor_txwrite while full: byte is dropped and tx_overflow sets.
//  - Pop of an empty FIFO is ignored. host_wr_valid while not ready is ignored.
//  - Status inputs are registered once. Edge detection runs on the registered copy.
//  - corr_count increments on each rising edge of status_correction.
//    uncorr_count increments on each rising edge of status_uncorrectable.
//    Both counters saturate at all-ones.
//  - count_clear takes priority over an increment in the same cycle. The counter reads 0 next cycle.
//  - FSM (uses registered status):
//    - INIT -> OBSERVE when observation=1.
//    - OBSERVE -> CORRECT when correction=1.
//    - CORRECT -> OBSERVE when observation=1 and correction=0.
//    - Any state -> FAULT when uncorrectable=1; this transition has top priority.
//    - FAULT is left only by reset.
//  - Watchdog: counter runs only in OBSERVE and clears on each heartbeat and on leaving OBSERVE.
//    When it reaches HB_TIMEOUT, hb_timeout sets. It stays set until count_clear or reset.
// TESTING
//  - Reset, then 16 SEM writes 0x00..0x0F -> monitor_txfull=1 after the 16th.
//    A 17th write -> tx_overflow=1; host reads 0x00..0x0F in order.
//  - Host pushes "S\r" (0x53,0x0D); SEM pops one per cycle -> monitor_rxdata 0x53 then 0x0D, then monitor_rxempty=1.
//  - Status drive init -> observation -> correction pulse x3 -> observation:
//    sem_state goes 0 -> 1 -> 2 -> 1 and corr_count=3.
//  - CNT_WIDTH=4, 17 correction pulses -> corr_count=15.
//    count_clear coincident with a pulse -> corr_count=0.
//  - In OBSERVE, hold heartbeat low for HB_TIMEOUT cycles -> hb_timeout=1.
//    A heartbeat every HB_TIMEOUT-1 cycles -> hb_timeout stays 0.
//  - uncorrectable=1 while in CORRECT -> sem_state=3 and uncorr_count=1.
//    Observation then returns -> sem_state stays 3. Reset -> sem_state=0.

Source files
------------

// File: rtl/sem_monitor_bridge.sv
// SEM monitor bridge: byte FIFOs between the SEM monitor port and an on-chip host,
// SEM phase tracking, saturating event counters and a heartbeat watchdog.

module sem_monitor_bridge_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       clk_icap,
   input  logic       reset,
   input  logic       push_i,
   input  logic [7:0] wdata_i,
   input  logic       pop_i,
   output logic [7:0] rdata_o,
   output logic       full_o,
   output logic       empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk_icap) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_icap) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// state    | meaning
// INIT     | SEM initialising, waiting for observation
// OBSERVE  | scanning; heartbeat watchdog active
// CORRECT  | correction in progress
// FAULT    | uncorrectable error seen, held until reset
module sem_monitor_bridge #(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_WIDTH  = 16,
   parameter int HB_TIMEOUT = 1024
) (
   input  logic                 clk_icap,
   input  logic                 reset,
   input  logic                 status_heartbeat,
   input  logic                 status_initialization,
   input  logic                 status_observation,
   input  logic                 status_correction,
   input  logic                 status_uncorrectable,
   input  logic [7:0]           monitor_txdata,
   input  logic                 monitor_txwrite,
   output logic                 monitor_txfull,
   output logic [7:0]           monitor_rxdata,
   input  logic                 monitor_rxread,
   output logic                 monitor_rxempty,
   output logic [7:0]           host_rd_data,
   output logic                 host_rd_valid,
   input  logic                 host_rd_ready,
   input  logic [7:0]           host_wr_data,
   input  logic                 host_wr_valid,
   output logic                 host_wr_ready,
   input  logic                 count_clear,
   output logic [CNT_WIDTH-1:0] corr_count,
   output logic [CNT_WIDTH-1:0] uncorr_count,
   output logic                 hb_timeout,
   output logic                 tx_overflow,
   output logic [1:0]           sem_state
);
   localparam int WDW = $clog2(HB_TIMEOUT + 1);
   localparam logic [WDW-1:0] WD_MAX = WDW'(HB_TIMEOUT);

   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_OBSERVE = 2'd1,
      ST_CORRECT = 2'd2,
      ST_FAULT   = 2'd3
   } state_t;

   state_t               state_q;
   logic                 hb_q, obs_q, corr_q, uncorr_q, corr_prev_q, uncorr_prev_q;
   logic                 corr_rise, uncorr_rise;
   logic [CNT_WIDTH-1:0] corr_count_q, corr_count_d, uncorr_count_q, uncorr_count_d;
   logic [WDW-1:0]       wd_q, wd_d;
   logic                 hb_timeout_q, tx_overflow_q;
   logic                 tx_empty, rx_full;
   logic                 init_unused;

   // The INIT phase is implied by the FSM state; the input is kept for port compatibility.
   assign init_unused = status_initialization;

   sem_monitor_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk_icap (clk_icap),
      .reset    (reset),
      .push_i   (monitor_txwrite),
      .wdata_i  (monitor_txdata),
      .pop_i    (host_rd_ready),
      .rdata_o  (host_rd_data),
      .full_o   (monitor_txfull),
      .empty_o  (tx_empty)
   );

   sem_monitor_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk_icap (clk_icap),
      .reset    (reset),
      .push_i   (host_wr_valid),
      .wdata_i  (host_wr_data),
      .pop_i    (monitor_rxread),
      .rdata_o  (monitor_rxdata),
      .full_o   (rx_full),
      .empty_o  (monitor_rxempty)
   );

   assign host_rd_valid = !tx_empty;
   assign host_wr_ready = !rx_full;
   assign corr_rise     = corr_q && !corr_prev_q;
   assign uncorr_rise   = uncorr_q && !uncorr_prev_q;

   always_comb begin
      corr_count_d   = corr_count_q;
      uncorr_count_d = uncorr_count_q;
      wd_d           = '0;
      if (count_clear) begin
         corr_count_d   = '0;
         uncorr_count_d = '0;
      end else begin
         if (corr_rise && corr_count_q != '1)     corr_count_d   = corr_count_q + CNT_WIDTH'(1);
         if (uncorr_rise && uncorr_count_q != '1) uncorr_count_d = uncorr_count_q + CNT_WIDTH'(1);
      end
      if (state_q == ST_OBSERVE && !hb_q) wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WDW'(1);
   end

   always_ff @(posedge clk_icap) begin
      if (reset) begin
         hb_q           <= 1'b0;
         obs_q          <= 1'b0;
         corr_q         <= 1'b0;
         uncorr_q       <= 1'b0;
         corr_prev_q    <= 1'b0;
         uncorr_prev_q  <= 1'b0;
         corr_count_q   <= '0;
         uncorr_count_q <= '0;
         wd_q           <= '0;
         hb_timeout_q   <= 1'b0;
         tx_overflow_q  <= 1'b0;
      end else begin
         hb_q           <= status_heartbeat;
         obs_q          <= status_observation;
         corr_q         <= status_correction;
         uncorr_q       <= status_uncorrectable;
         corr_prev_q    <= corr_q;
         uncorr_prev_q  <= uncorr_q;
         corr_count_q   <= corr_count_d;
         uncorr_count_q <= uncorr_count_d;
         wd_q           <= wd_d;
         if (count_clear)             hb_timeout_q <= 1'b0;
         else if (wd_q == WD_MAX)     hb_timeout_q <= 1'b1;
         if (count_clear)                          tx_overflow_q <= 1'b0;
         else if (monitor_txwrite && monitor_txfull) tx_overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_icap) begin
      if (reset) begin
         state_q <= ST_INIT;
      end else if (uncorr_q) begin
         state_q <= ST_FAULT;
      end else begin
         case (state_q)
            ST_INIT:    if (obs_q) state_q <= ST_OBSERVE;
            ST_OBSERVE: if (corr_q) state_q <= ST_CORRECT;
            ST_CORRECT: if (obs_q && !corr_q) state_q <= ST_OBSERVE;
            default:    state_q <= ST_FAULT;
         endcase
      end
   end

   assign corr_count   = corr_count_q;
   assign uncorr_count = uncorr_count_q;
   assign hb_timeout   = hb_timeout_q;
   assign tx_overflow  = tx_overflow_q;
   assign sem_state    = state_q;
endmodule

// File: tb/tb_sem_monitor_bridge.sv
// Bench for sem_monitor_bridge: queue/arithmetic reference model compared every cycle,
// plus directed scenarios with literal expectations.

module tb_sem_monitor_bridge;
   localparam int DEPTH = 16;
   localparam int CW    = 4;
   localparam int HB    = 32;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk_icap = 1'b0;
   logic          reset;
   logic          status_heartbeat, status_initialization, status_observation;
   logic          status_correction, status_uncorrectable;
   logic [7:0]    monitor_txdata;
   logic          monitor_txwrite, monitor_txfull;
   logic [7:0]    monitor_rxdata;
   logic          monitor_rxread, monitor_rxempty;
   logic [7:0]    host_rd_data;
   logic          host_rd_valid, host_rd_ready;
   logic [7:0]    host_wr_data;
   logic          host_wr_valid, host_wr_ready;
   logic          count_clear;
   logic [CW-1:0] corr_count, uncorr_count;
   logic          hb_timeout, tx_overflow;
   logic [1:0]    sem_state;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 0;

   sem_monitor_bridge #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW), .HB_TIMEOUT(HB)) dut (
      .clk_icap(clk_icap), .reset(reset),
      .status_heartbeat(status_heartbeat), .status_initialization(status_initialization),
      .status_observation(status_observation), .status_correction(status_correction),
      .status_uncorrectable(status_uncorrectable),
      .monitor_txdata(monitor_txdata), .monitor_txwrite(monitor_txwrite), .monitor_txfull(monitor_txfull),
      .monitor_rxdata(monitor_rxdata), .monitor_rxread(monitor_rxread), .monitor_rxempty(monitor_rxempty),
      .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready),
      .host_wr_data(host_wr_data), .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
      .count_clear(count_clear), .corr_count(corr_count), .uncorr_count(uncorr_count),
      .hb_timeout(hb_timeout), .tx_overflow(tx_overflow), .sem_state(sem_state)
   );

   always #5 clk_icap = ~clk_icap;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFOs as queues, phase/counters from the status rules.
   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   int  m_corr, m_uncorr, m_state, m_gap, m_nxt;
   bit  m_hbto, m_ovf;
   bit  r_hb, r_obs, r_corr, r_unc, p_corr, p_unc;
   bit  txf, txe, rxf, rxe;

   always @(posedge clk_icap) begin
      if (reset) begin
         tx_q.delete(); rx_q.delete();
         m_corr = 0; m_uncorr = 0; m_state = 0; m_gap = 0; m_hbto = 0; m_ovf = 0;
         r_hb = 0; r_obs = 0; r_corr = 0; r_unc = 0; p_corr = 0; p_unc = 0;
      end else begin
         txf = (tx_q.size() == DEPTH); txe = (tx_q.size() == 0);
         rxf = (rx_q.size() == DEPTH); rxe = (rx_q.size() == 0);
         if (host_rd_ready && !txe) void'(tx_q.pop_front());
         if (monitor_txwrite && !txf) tx_q.push_back(monitor_txdata);
         if (monitor_rxread && !rxe) void'(rx_q.pop_front());
         if (host_wr_valid && !rxf) rx_q.push_back(host_wr_data);
         if (count_clear) m_ovf = 0; else if (monitor_txwrite && txf) m_ovf = 1;
         if (count_clear) begin
            m_corr = 0; m_uncorr = 0;
         end else begin
            if (r_corr && !p_corr && m_corr < CMAX) m_corr++;
            if (r_unc && !p_unc && m_uncorr < CMAX) m_uncorr++;
         end
         if (count_clear) m_hbto = 0; else if (m_gap >= HB) m_hbto = 1;
         if (m_state == 1 && !r_hb) m_gap = (m_gap < HB) ? m_gap + 1 : HB; else m_gap = 0;
         m_nxt = m_state;
         if (r_unc) m_nxt = 3;
         else if (m_state == 0 && r_obs) m_nxt = 1;
         else if (m_state == 1 && r_corr) m_nxt = 2;
         else if (m_state == 2 && r_obs && !r_corr) m_nxt = 1;
         m_state = m_nxt;
         p_corr = r_corr; p_unc = r_unc;
         r_hb = status_heartbeat; r_obs = status_observation;
         r_corr = status_correction; r_unc = status_uncorrectable;
      end
   end

   always @(negedge clk_icap) begin
      if (cmp_en) begin
         check("txfull", monitor_txfull, tx_q.size() == DEPTH);
         check("rd_valid", host_rd_valid, tx_q.size() != 0);
         if (tx_q.size() != 0) check("rd_data", host_rd_data, tx_q[0]);
         check("rxempty", monitor_rxempty, rx_q.size() == 0);
         check("wr_ready", host_wr_ready, rx_q.size() != DEPTH);
         if (rx_q.size() != 0) check("rxdata", monitor_rxdata, rx_q[0]);
         check("corr_count", corr_count, m_corr);
         check("uncorr_count", uncorr_count, m_uncorr);
         check("hb_timeout", hb_timeout, m_hbto);
         check("tx_overflow", tx_overflow, m_ovf);
         check("sem_state", sem_state, m_state);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_icap);
   endtask

   task automatic corr_pulse();
      status_correction = 1; cyc(1);
      status_correction = 0; cyc(1);
   endtask

   initial begin
      reset = 1;
      {status_heartbeat, status_initialization, status_observation, status_correction, status_uncorrectable} = '0;
      monitor_txdata = 0; monitor_txwrite = 0; monitor_rxread = 0;
      host_rd_ready = 0; host_wr_data = 0; host_wr_valid = 0; count_clear = 0;
      cyc(2);
      reset = 0; cmp_en = 1;
      check("rst_txfull", monitor_txfull, 0);
      check("rst_rxempty", monitor_rxempty, 1);
      check("rst_valid", host_rd_valid, 0);
      check("rst_ready", host_wr_ready, 1);
      check("rst_state", sem_state, 0);
      check("rst_corr", corr_count, 0);

      // TX fill to full, overflow, drain in order
      for (int i = 0; i < 16; i++) begin
         monitor_txdata = 8'(i); monitor_txwrite = 1; cyc(1);
      end
      monitor_txwrite = 0;
      check("txfull_16", monitor_txfull, 1);
      monitor_txdata = 8'hAA; monitor_txwrite = 1; cyc(1);
      monitor_txwrite = 0;
      check("overflow_17", tx_overflow, 1);
      host_rd_ready = 1;
      for (int i = 0; i < 16; i++) begin
         check("host_order", host_rd_data, i);
         cyc(1);
      end
      host_rd_ready = 0;
      check("tx_drained", host_rd_valid, 0);

      // zero-bubble streaming from empty
      host_rd_ready = 1;
      for (int i = 0; i < 6; i++) begin
         monitor_txdata = 8'(8'h20 + i); monitor_txwrite = 1; cyc(1);
         if (i == 0) check("stream_first", host_rd_data, 8'h20);
      end
      monitor_txwrite = 0; cyc(2);
      host_rd_ready = 0;
      check("stream_done", host_rd_valid, 0);

      // host command "S\r" into RX, SEM pops one per cycle
      host_wr_data = 8'h53; host_wr_valid = 1; cyc(1);
      host_wr_data = 8'h0D; cyc(1);
      host_wr_valid = 0;
      monitor_rxread = 1;
      check("rx_first", monitor_rxdata, 8'h53); cyc(1);
      check("rx_second", monitor_rxdata, 8'h0D); cyc(1);
      check("rx_empty", monitor_rxempty, 1); cyc(1);
      monitor_rxread = 0;

      // phase tracking: init -> observe -> 3x correction -> observe
      status_initialization = 1; cyc(3);
      check("st_init", sem_state, 0);
      status_initialization = 0; status_observation = 1; cyc(3);
      check("st_observe", sem_state, 1);
      for (int k = 0; k < 3; k++) begin
         status_correction = 1; cyc(1);
         status_correction = 0; cyc(1);
         check("st_correct", sem_state, 2);
         cyc(2);
         check("st_back_obs", sem_state, 1);
      end
      check("corr_3", corr_count, 3);

      // saturation and clear priority
      count_clear = 1; cyc(1); count_clear = 0;
      check("ovf_cleared", tx_overflow, 0);
      for (int k = 0; k < 17; k++) corr_pulse();
      cyc(2);
      check("corr_sat", corr_count, 15);
      status_correction = 1; count_clear = 1; cyc(1);
      status_correction = 0; cyc(1);
      count_clear = 0; cyc(1);
      check("clear_prio", corr_count, 0);
      cyc(3);

      // watchdog
      count_clear = 1; cyc(1); count_clear = 0;
      for (int k = 0; k < 4; k++) begin
         status_heartbeat = 1; cyc(1);
         status_heartbeat = 0; cyc(HB - 2);
      end
      check("hb_kept", hb_timeout, 0);
      cyc(HB + 4);
      check("hb_expired", hb_timeout, 1);
      status_heartbeat = 1; cyc(1);
      status_heartbeat = 0; count_clear = 1; cyc(1);
      count_clear = 0; cyc(1);
      check("hb_cleared", hb_timeout, 0);

      // uncorrectable while correcting
      status_correction = 1; cyc(3);
      check("st_corr_hold", sem_state, 2);
      status_uncorrectable = 1; cyc(1);
      status_uncorrectable = 0; cyc(3);
      check("st_fault", sem_state, 3);
      check("uncorr_1", uncorr_count, 1);
      status_correction = 0; cyc(4);
      check("fault_sticky", sem_state, 3);

      // reset mid-transfer
      status_observation = 0;
      monitor_txwrite = 1; host_wr_valid = 1;
      for (int i = 0; i < 3; i++) begin
         monitor_txdata = 8'(8'h40 + i); host_wr_data = 8'(8'h60 + i); cyc(1);
      end
      check("pre_rst_valid", host_rd_valid, 1);
      reset = 1; cyc(1);
      monitor_txwrite = 0; host_wr_valid = 0; reset = 0; cyc(1);
      check("post_rst_state", sem_state, 0);
      check("post_rst_valid", host_rd_valid, 0);
      check("post_rst_rxempty", monitor_rxempty, 1);
      check("post_rst_uncorr", uncorr_count, 0);
      cyc(2);

      cmp_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
